uart_rx: RTL and testbench

UART receiver; the receive-side counterpart of the team's uart_tx. Recovers 8N1 frames from the asynchronous rx line using a 16x oversampling tick (baud_clk) from the shared baud generator. Presents each received byte with a one-cycle valid pulse and flags framing errors. Holds the baud generator in reset while idle so sampling phase aligns to the start-bit edge.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_sync.sv | 30 +++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels, oversampling constants
// and the 2-of-3 majority helper used by receivers that vote on samples.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

  localparam logic START      = 1'b0;
  localparam logic STOP       = 1'b1;
  localparam int   OVERSAMPLE = 16;
  localparam int   MID_SAMPLE = 7;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line and baud tick in, received byte and status out.
// slave is the receiver's view, master is the view of whoever drives the line.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_clk;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_data_valid;
  logic                 rx_frame_err;
  logic                 rx_busy;
  logic                 baud_rst;

  modport master (
    output baud_clk, rx,
    input  rx_data_o, rx_data_valid, rx_frame_err, rx_busy, baud_rst
  );

  modport slave (
    input  baud_clk, rx,
    output rx_data_o, rx_data_valid, rx_frame_err, rx_busy, baud_rst
  );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input that idles high,
// with a falling-edge strobe derived from the synchronized value.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic line_s,
  output logic fall_s
);

  logic [SYNC_STAGES-1:0] stage_r;
  logic                   prev_r;

  // Shift the line through the chain and remember the previous synchronized value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_r <= {SYNC_STAGES{1'b1}};
      prev_r  <= 1'b1;
    end else begin
      stage_r <= {stage_r[SYNC_STAGES-2:0], line};
      prev_r  <= stage_r[SYNC_STAGES-1];
    end
  end

  assign line_s = stage_r[SYNC_STAGES-1];
  assign fall_s = prev_r & ~line_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x oversampling tick; holds the baud generator in reset while idle.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote over sample_cnt 6/7/8 instead of one mid-bit sample.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE + 1);
`else
  localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE);
`endif
  localparam logic [3:0]       LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS);

  uart_state_e          state_r;
  logic [3:0]           sample_cnt_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 rx_s;
  logic                 fall_s;
  logic                 decide_s;
  logic                 bit_end_s;
  logic                 bit_v_s;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .line   (bus.rx),
    .line_s (rx_s),
    .fall_s (fall_s)
  );

  assign decide_s  = bus.baud_clk & (sample_cnt_r == DECIDE_CNT);
  assign bit_end_s = bus.baud_clk & (sample_cnt_r == LAST_CNT);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_r;

  // Capture the two samples that precede the decision tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      early_r <= 2'b11;
    end else if (bus.baud_clk && (sample_cnt_r == DECIDE_CNT - 4'd2)) begin
      early_r[0] <= rx_s;
    end else if (bus.baud_clk && (sample_cnt_r == DECIDE_CNT - 4'd1)) begin
      early_r[1] <= rx_s;
    end else begin
      early_r <= early_r;
    end
  end

  assign bit_v_s = majority3(early_r[0], early_r[1], rx_s);
`else
  assign bit_v_s = rx_s;
`endif

  // Frame FSM: sample phase counting, bit assembly and the one-cycle result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      sample_cnt_r      <= 4'd0;
      bit_cnt_r         <= '0;
      shift_r           <= '0;
      bus.rx_data_o     <= '0;
      bus.rx_data_valid <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
    end else begin
      bus.rx_data_valid <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
      if (state_r == IDLE) begin
        sample_cnt_r <= 4'd0;
      end else if (bus.baud_clk) begin
        sample_cnt_r <= sample_cnt_r + 4'd1;
      end
      case (state_r)
        IDLE: begin
          bit_cnt_r <= '0;
          if (fall_s) state_r <= START_BIT;
        end
        START_BIT: begin
          bit_cnt_r <= '0;
          // A start that is high again at mid-bit was only a glitch
          if (decide_s && (bit_v_s != START)) state_r <= IDLE;
          else if (bit_end_s) state_r <= uart_pkg::DATA_BITS;
        end
        uart_pkg::DATA_BITS: begin
          if (decide_s) begin
            shift_r   <= {bit_v_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
          if (bit_end_s && (bit_cnt_r == LAST_BIT)) state_r <= STOP_BIT;
        end
        STOP_BIT: begin
          bit_cnt_r <= '0;
          // Leave at mid stop bit so an immediately following start edge is seen
          if (decide_s) begin
            if (bit_v_s == STOP) begin
              bus.rx_data_o     <= shift_r;
              bus.rx_data_valid <= 1'b1;
            end else begin
              bus.rx_frame_err  <= 1'b1;
            end
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.rx_busy  = (state_r != IDLE);
  assign bus.baud_rst = (state_r == IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random 8N1 frames checked against a frame-level model
// (good frame -> byte, bad stop -> error with the last good byte held).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bcnt;
  int         tests_run = 0;
  int         tests_failed = 0;
  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         both_cnt = 0;
  logic       busy_at_valid;
  logic [7:0] last_good = 8'h00;

  uart_rx_if #(.DATA_BITS(8)) bif ();

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  // Baud generator model: held at zero while baud_rst, otherwise a tick every 4 clk
  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 2'd0;
    else if (bif.baud_rst) bcnt <= 2'd0;
    else bcnt <= bcnt + 2'd1;
  end
  assign bif.baud_clk = (bcnt == 2'd3);

  // Output monitor: record every result pulse with the byte visible at that time
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bif.rx_data_valid && bif.rx_frame_err) both_cnt <= both_cnt + 1;
      if (bif.rx_data_valid) begin
        obs_q.push_back('{err: 1'b0, data: bif.rx_data_o});
        busy_at_valid <= bif.rx_busy;
      end else if (bif.rx_frame_err) begin
        obs_q.push_back('{err: 1'b1, data: bif.rx_data_o});
      end
    end
  end

  task automatic model_frame(input logic [7:0] d, input logic stop_v);
    if (stop_v) begin
      last_good = d;
      exp_q.push_back('{err: 1'b0, data: d});
    end else begin
      exp_q.push_back('{err: 1'b1, data: last_good});
    end
  endtask

  // Must be called at a negedge; leaves rx at the stop level
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    logic [9:0] bits;
    bits = {stop_v, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bif.rx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.rx = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bif.rx_data_o, bif.rx_data_valid, bif.rx_frame_err, bif.rx_busy, bif.baud_rst} !== {8'h00, 4'b0001}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h v=%b e=%b busy=%b brst=%b want 00 0 0 0 1",
               bif.rx_data_o, bif.rx_data_valid, bif.rx_frame_err, bif.rx_busy, bif.baud_rst);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (bif.rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b want 0", bif.rx_busy);
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    repeat (16) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d events want 1", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL basic_data: got err=%b data=%h want err=%b data=%h",
                 obs_q[0].err, obs_q[0].data, exp_q[0].err, exp_q[0].data);
      end
    end
    tests_run++;
    if (busy_at_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy_at_stop: busy=%b want 0", busy_at_valid);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_break();
    bif.rx = 1'b0;
    repeat (20) @(negedge clk);
    bif.rx = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if ({bif.baud_rst, bif.rx_busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL glitch_start_idle: brst=%b busy=%b want 1 0", bif.baud_rst, bif.rx_busy);
    end
    repeat (700) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL glitch_start_pulse: got %0d events want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    repeat (300) @(negedge clk);
    tests_run++;
    if (bif.rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL break_no_start: busy=%b want 0", bif.rx_busy);
    end
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL frame_err_event: got n=%0d first=%h want n=1 %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, exp_q[0]);
    end
    obs_q.delete();
    exp_q.delete();
    bif.rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    repeat (16) @(negedge clk);
    tests_run++;
    if (bif.rx_data_o !== last_good) begin
      tests_failed++;
      $display("FAIL recover_after_err: data=%h want %h", bif.rx_data_o, last_good);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    repeat (16) @(negedge clk);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL b2b_event: got err=%b data=%h want err=%b data=%h", o.err, o.data, e.err, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bif.rx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    bif.rx = 1'b1;
    #1;
    tests_run++;
    if ({bif.rx_data_o, bif.rx_data_valid, bif.rx_frame_err, bif.rx_busy} !== 11'h000) begin
      tests_failed++;
      $display("FAIL async_reset: got data=%h v=%b e=%b busy=%b want all 0",
               bif.rx_data_o, bif.rx_data_valid, bif.rx_frame_err, bif.rx_busy);
    end
    last_good = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    repeat (16) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL after_reset_frame: got n=%0d first=%h want n=1 %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, exp_q[0]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch();
    logic [9:0] bits;
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h04;
`endif
    bits = {1'b1, 8'h00, 1'b0};
    // Pulse high for 3 clk so only the sample_cnt 7 tick of data bit 2 sees it
    for (int c = 0; c < 10 * BIT_CLKS; c++) begin
      bif.rx = (c >= 223 && c <= 225) ? 1'b1 : bits[c / BIT_CLKS];
      @(negedge clk);
    end
    repeat (16) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 1 || bif.rx_data_o !== want) begin
      tests_failed++;
      $display("FAIL glitch_bit2: got n=%0d data=%h want n=1 data=%h", obs_q.size(), bif.rx_data_o, want);
    end
    last_good = want;
    obs_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, s);
      model_frame(d, s);
      bif.rx = 1'b1;
      repeat (s ? $urandom_range(0, 30) : 16 + $urandom_range(0, 30)) @(negedge clk);
    end
    repeat (16) @(negedge clk);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL random_event: got err=%b data=%h want err=%b data=%h", o.err, o.data, e.err, e.data);
      end
    end
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++;
      $display("FAIL valid_and_err_together: got %0d cycles want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
